// File: rtl/accel_poll_sequencer.sv
// Sequencer ahead of the I2C controller: configures the accelerometer with two writes, then
// polls its six data registers once per tick and publishes coherent X/Y/Z samples.
module accel_poll_sequencer #(
  parameter int         SYS_CLK_SPEED  = 50000000,
  parameter int         SAMPLE_RATE_HZ = 100,
  parameter logic [6:0] ACCEL_ADDR     = 7'h1D,
  parameter int         TIMEOUT_CYCLES = 1000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  output logic [6:0]  i2c_dev_addr,
  output logic [7:0]  i2c_reg_addr,
  output logic        i2c_r_w,
  output logic [7:0]  i2c_write_data,
  output logic        i2c_start,
  input  logic [7:0]  i2c_read_data,
  input  logic        i2c_finished,
  input  logic        i2c_ready,
  output logic [15:0] accel_x,
  output logic [15:0] accel_y,
  output logic [15:0] accel_z,
  output logic        sample_valid,
  output logic        sample_overrun,
  output logic        init_done,
  output logic        seq_error
);
  localparam int TICK_CNT = SYS_CLK_SPEED / SAMPLE_RATE_HZ;
  localparam int TW = $clog2(TICK_CNT + 1);
  localparam int OW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {
    INIT_ISSUE, INIT_WAIT, IDLE, RD_ISSUE, RD_WAIT, PUBLISH, ERROR
  } state_t;

  state_t        state_q;
  logic [2:0]    idx_q;
  logic          fin_q;
  logic [TW-1:0] tick_q;
  logic [OW-1:0] tmo_q;
  logic [7:0]    sh_q [6];
  logic          done, tick, tmo_hit, issue_ok;

  assign i2c_dev_addr = ACCEL_ADDR;
  // Only a fresh rising edge of finished counts; a level left high from before is ignored.
  assign done     = i2c_finished & ~fin_q;
  assign tick     = init_done && (tick_q == TW'(TICK_CNT - 1));
  assign tmo_hit  = (tmo_q == OW'(TIMEOUT_CYCLES - 1));
  assign issue_ok = enable && i2c_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= INIT_ISSUE;
      idx_q          <= '0;
      fin_q          <= 1'b0;
      tick_q         <= '0;
      tmo_q          <= '0;
      i2c_reg_addr   <= '0;
      i2c_r_w        <= 1'b0;
      i2c_write_data <= '0;
      i2c_start      <= 1'b0;
      accel_x        <= '0;
      accel_y        <= '0;
      accel_z        <= '0;
      sample_valid   <= 1'b0;
      sample_overrun <= 1'b0;
      init_done      <= 1'b0;
      seq_error      <= 1'b0;
      for (int i = 0; i < 6; i++) sh_q[i] <= '0;
    end else begin
      fin_q          <= i2c_finished;
      i2c_start      <= 1'b0;
      sample_valid   <= 1'b0;
      sample_overrun <= 1'b0;
      if (init_done) tick_q <= tick ? '0 : tick_q + 1'b1;
      if (tick && state_q != IDLE && state_q != ERROR) sample_overrun <= 1'b1;
      case (state_q)
        INIT_ISSUE: if (issue_ok) begin
          i2c_start      <= 1'b1;
          i2c_r_w        <= 1'b0;
          i2c_reg_addr   <= idx_q[0] ? 8'h2D : 8'h31;
          i2c_write_data <= idx_q[0] ? 8'h08 : 8'h0B;
          tmo_q          <= '0;
          state_q        <= INIT_WAIT;
        end
        INIT_WAIT: begin
          if (done) begin
            if (idx_q[0]) begin
              init_done <= 1'b1;
              tick_q    <= '0;
              idx_q     <= '0;
              state_q   <= IDLE;
            end else begin
              idx_q   <= 3'd1;
              state_q <= INIT_ISSUE;
            end
          end else if (tmo_hit) begin
            seq_error <= 1'b1;
            state_q   <= ERROR;
          end else begin
            tmo_q <= tmo_q + 1'b1;
          end
        end
        IDLE: if (tick && enable) begin
          idx_q   <= '0;
          state_q <= RD_ISSUE;
        end
        // Parks here while enable is low; shadow bytes already read are kept.
        RD_ISSUE: if (issue_ok) begin
          i2c_start      <= 1'b1;
          i2c_r_w        <= 1'b1;
          i2c_reg_addr   <= 8'h32 + {5'd0, idx_q};
          i2c_write_data <= '0;
          tmo_q          <= '0;
          state_q        <= RD_WAIT;
        end
        RD_WAIT: begin
          if (done) begin
            sh_q[idx_q] <= i2c_read_data;
            if (idx_q == 3'd5) begin
              state_q <= PUBLISH;
            end else begin
              idx_q   <= idx_q + 1'b1;
              state_q <= RD_ISSUE;
            end
          end else if (tmo_hit) begin
            seq_error <= 1'b1;
            state_q   <= ERROR;
          end else begin
            tmo_q <= tmo_q + 1'b1;
          end
        end
        PUBLISH: begin
          accel_x      <= {sh_q[1], sh_q[0]};
          accel_y      <= {sh_q[3], sh_q[2]};
          accel_z      <= {sh_q[5], sh_q[4]};
          sample_valid <= 1'b1;
          state_q      <= IDLE;
        end
        ERROR: ;
        default: state_q <= ERROR;
      endcase
    end
  end
endmodule

// File: tb/tb_accel_poll_sequencer.sv
// Bench for accel_poll_sequencer: I2C controller model with random read data and a
// transaction-log based reference for every published sample.
module tb_accel_poll_sequencer;
  localparam int TMO = 300;

  logic        clk = 0, rst, enable;
  logic [6:0]  i2c_dev_addr;
  logic [7:0]  i2c_reg_addr, i2c_write_data, i2c_read_data;
  logic        i2c_r_w, i2c_start, i2c_finished, i2c_ready;
  logic [15:0] accel_x, accel_y, accel_z;
  logic        sample_valid, sample_overrun, init_done, seq_error;

  accel_poll_sequencer #(.SYS_CLK_SPEED(2000), .SAMPLE_RATE_HZ(10), .ACCEL_ADDR(7'h1D),
                         .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst(rst), .enable(enable), .i2c_dev_addr(i2c_dev_addr),
    .i2c_reg_addr(i2c_reg_addr), .i2c_r_w(i2c_r_w), .i2c_write_data(i2c_write_data),
    .i2c_start(i2c_start), .i2c_read_data(i2c_read_data), .i2c_finished(i2c_finished),
    .i2c_ready(i2c_ready), .accel_x(accel_x), .accel_y(accel_y), .accel_z(accel_z),
    .sample_valid(sample_valid), .sample_overrun(sample_overrun), .init_done(init_done),
    .seq_error(seq_error));

  always #5 clk = ~clk;

  int checks = 0, errors = 0, cyc = 0, nsv = 0, nov = 0, viol = 0, lat = 4;
  bit hang = 0;
  logic [16:0] txq[$];   // {reg, r_w, wdata} per start
  logic [15:0] rdlog[$]; // {reg, byte} per completed read
  logic [7:0]  dq[$];    // directed read bytes, used before random ones

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Controller model
  initial begin : ctrl
    bit busy = 0, cur_rw = 0;
    int cnt = 0;
    logic [7:0] cur_reg = 0, b;
    i2c_ready = 1; i2c_finished = 0; i2c_read_data = 0;
    forever begin
      @(posedge clk); #1;
      if (rst) begin
        busy = 0; i2c_finished = hang; i2c_ready = 1;
        continue;
      end
      if (!hang) begin
        if (i2c_finished) begin
          i2c_finished = 0; i2c_ready = 1; busy = 0;
        end else if (busy) begin
          if (cnt == 0) begin
            if (cur_rw) begin
              b = (dq.size() > 0) ? dq.pop_front() : 8'($urandom);
              i2c_read_data = b;
              rdlog.push_back({cur_reg, b});
            end
            i2c_finished = 1;
          end else cnt--;
        end
      end
      if (i2c_start) begin
        if (busy) viol++;
        busy = 1; i2c_ready = 0; cnt = lat;
        cur_reg = i2c_reg_addr; cur_rw = i2c_r_w;
        txq.push_back({i2c_reg_addr, i2c_r_w, i2c_write_data});
      end
    end
  end

  // Every published sample must be exactly the last six reads, in register order.
  initial begin : mon
    int n;
    logic [7:0] e[6];
    forever begin
      @(negedge clk);
      if (sample_overrun) nov++;
      if (sample_valid) begin
        nsv++;
        n = rdlog.size();
        chk("burst_len", 32'(n >= 6), 32'd1);
        if (n >= 6) begin
          for (int k = 0; k < 6; k++) begin
            chk("burst_reg", 32'(rdlog[n-6+k][15:8]), 32'(8'h32 + k));
            e[k] = rdlog[n-6+k][7:0];
          end
          chk("smp_x", 32'(accel_x), 32'({e[1], e[0]}));
          chk("smp_y", 32'(accel_y), 32'({e[3], e[2]}));
          chk("smp_z", 32'(accel_z), 32'({e[5], e[4]}));
        end
      end
    end
  end

  task automatic wait_sv(input int budget, output bit ok);
    ok = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (sample_valid) begin ok = 1; break; end
    end
  endtask

  task automatic wait_init(input int budget, output bit ok);
    ok = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (init_done) begin ok = 1; break; end
    end
  endtask

  task automatic wait_start_reg(input logic [7:0] r, input int budget, output bit ok);
    int sz0 = txq.size();
    ok = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (txq.size() > sz0 && txq[txq.size()-1][16:9] == r) begin ok = 1; break; end
    end
  endtask

  initial begin : main
    bit ok;
    int sz, s, o, bursts, t0;
    enable = 1; rst = 1;
    repeat (3) @(negedge clk);
    chk("rst_start", 32'(i2c_start), 32'd0);
    chk("rst_dev", 32'(i2c_dev_addr), 32'h1D);
    chk("rst_init", 32'(init_done), 32'd0);
    chk("rst_x", 32'(accel_x), 32'd0);
    chk("rst_err", 32'(seq_error), 32'd0);
    chk("rst_sv", 32'({sample_valid, sample_overrun}), 32'd0);
    rst = 0;

    // Configuration writes
    wait_init(200, ok);
    chk("init_wait", 32'(ok), 32'd1);
    chk("init_ntx", 32'(txq.size()), 32'd2);
    chk("init_w0", 32'(txq[0]), 32'({8'h31, 1'b0, 8'h0B}));
    chk("init_w1", 32'(txq[1]), 32'({8'h2D, 1'b0, 8'h08}));

    // Directed burst
    dq = '{8'h10, 8'h00, 8'hF0, 8'hFF, 8'h00, 8'h01};
    s = nsv;
    wait_sv(600, ok);
    chk("b1_wait", 32'(ok), 32'd1);
    chk("b1_x", 32'(accel_x), 32'h0010);
    chk("b1_y", 32'(accel_y), 32'hFFF0);
    chk("b1_z", 32'(accel_z), 32'h0100);
    for (int k = 0; k < 6; k++) chk("b1_rd", 32'(txq[2+k][16:8]), 32'({8'h32 + 8'(k), 1'b1}));
    repeat (3) @(negedge clk);
    chk("b1_svcnt", 32'(nsv - s), 32'd1);

    // Enable dropped with read index 2 in flight
    wait_start_reg(8'h34, 600, ok);
    chk("en_wait", 32'(ok), 32'd1);
    enable = 0;
    sz = txq.size(); s = nsv;
    repeat (lat + 40) @(negedge clk);
    chk("en_nostart", 32'(txq.size()), 32'(sz));
    chk("en_idx2done", 32'(rdlog[rdlog.size()-1][15:8]), 32'h34);
    chk("en_nosv", 32'(nsv), 32'(s));
    enable = 1;
    wait_sv(200, ok);
    chk("en_sv", 32'(ok), 32'd1);
    chk("en_ntx", 32'(txq.size()), 32'(sz + 3));
    for (int k = 0; k < 3; k++) chk("en_rd", 32'(txq[sz+k][16:9]), 32'(8'h35 + k));

    // Ticks while idle and disabled are discarded silently
    enable = 0; o = nov; sz = txq.size();
    repeat (450) @(negedge clk);
    chk("dis_noovr", 32'(nov), 32'(o));
    chk("dis_nostart", 32'(txq.size()), 32'(sz));
    enable = 1;

    // Bursts longer than the tick period
    lat = 60; sz = txq.size(); o = nov; s = nsv;
    repeat (2000) @(negedge clk);
    bursts = 0;
    for (int i = sz; i < txq.size(); i++) if (txq[i][16:9] == 8'h32) bursts++;
    chk("ovr_some", 32'((nov - o) >= 3), 32'd1);
    chk("ovr_ticks", 32'((nov - o + bursts) >= 8 && (nov - o + bursts) <= 11), 32'd1);
    chk("ovr_smp", 32'((nsv - s) >= 3), 32'd1);
    lat = 4;
    wait_sv(800, ok);
    chk("ovr_drain", 32'(ok), 32'd1);

    // Reset during RD_WAIT
    wait_start_reg(8'h33, 600, ok);
    chk("rs_wait", 32'(ok), 32'd1);
    rst = 1;
    @(negedge clk);
    chk("rs_x", 32'(accel_x), 32'd0);
    chk("rs_yz", 32'({accel_y, accel_z}), 32'd0);
    chk("rs_init", 32'(init_done), 32'd0);
    chk("rs_start", 32'(i2c_start), 32'd0);
    chk("rs_reg", 32'(i2c_reg_addr), 32'd0);
    rst = 0;
    sz = txq.size();
    wait_init(200, ok);
    chk("rs_reinit", 32'(ok), 32'd1);
    chk("rs_w0", 32'(txq[sz]), 32'({8'h31, 1'b0, 8'h0B}));
    chk("rs_w1", 32'(txq[sz+1]), 32'({8'h2D, 1'b0, 8'h08}));

    // Finished stuck high: timeout
    hang = 1; rst = 1;
    repeat (2) @(negedge clk);
    rst = 0;
    sz = txq.size(); ok = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (txq.size() > sz) begin ok = 1; break; end
    end
    chk("to_start", 32'(ok), 32'd1);
    t0 = cyc; ok = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (seq_error) begin ok = 1; break; end
    end
    chk("to_err", 32'(ok), 32'd1);
    chk("to_time", 32'((cyc - t0) >= TMO && (cyc - t0) <= TMO + 2), 32'd1);
    repeat (400) @(negedge clk);
    chk("to_nostart", 32'(txq.size()), 32'(sz + 1));
    chk("to_sticky", 32'(seq_error), 32'd1);
    chk("to_noinit", 32'(init_done), 32'd0);
    chk("ctrl_viol", 32'(viol), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #10ms;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end
endmodule
